rf_write_scheduler: RTL

- Owns the single write port of the 8x8 register file and shares it between two writers: the ALU writeback path and the data-memory load return path.
- Tracks at most one outstanding load (the memory has one port; completion is signalled when its BUSYWAIT falls).
- Holds a scoreboard of registers with writes not yet committed, and raises STALL to the control unit on RAW hazards.
- Queues ALU writes that lose arbitration, and drives the register file WRITE/INADDRESS/IN inputs from a registered writeback stage.

---
 rtl/rf_sched_pkg.sv | 22 ++
 rtl/rf_wq_fifo.sv | 84 ++++++++
 rtl/rf_write_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rf_sched_pkg.sv
// Shared definitions for the register-file write scheduler.
// Holds the register file geometry, the load-tracking FSM state type and
// the write-request record that travels through the ALU queue and the
// writeback stage.
package rf_sched_pkg;

  localparam int DATA_W          = 8;
  localparam int ADDR_W          = 3;
  localparam int NREG            = 1 << ADDR_W;
  localparam int QDEPTH_DEFAULT  = 2;

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } ld_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_wq_fifo.sv
// Small synchronous FIFO that buffers ALU writes which lost arbitration for
// the register file write port.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   push/push_data enqueue one request (ignored when full)
//   pop            drop the head entry (ignored when empty)
//   full/empty     occupancy flags
//   count          number of valid entries
//   entries        all slots in age order, entries[0] is the head; only the
//                  first 'count' are meaningful (used for hazard compares)
module rf_wq_fifo
  import rf_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wr_req_t                push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output wr_req_t [DEPTH-1:0]    entries
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wr_req_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                do_push, do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    count    = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // A simultaneous push and pop leaves the occupancy unchanged.
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Present the slots rotated so index 0 is always the oldest entry;
  // pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    entries = '0;
    for (int k = 0; k < DEPTH; k++) begin
      entries[k] = mem_q[rd_ptr_q + PW'(k)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Shares the single register file write port between the ALU writeback path
// and the data-memory load return path, tracks the one outstanding load,
// keeps a scoreboard of uncommitted writes and raises STALL on RAW hazards.
// Ports:
//   CLK, RESET                       clock, asynchronous active-low reset
//   ALU_REQ/ALU_ADDR/ALU_DATA/ALU_GNT ALU write request and combinational grant
//   LD_ISSUE/LD_ADDR                 load issued, destination register
//   LD_DONE/LD_DATA                  load data returned
//   SRC1_ADDR/SRC2_ADDR/STALL        decode sources and hazard stall
//   RF_WRITE/RF_INADDRESS/RF_IN      registered register file write port
//   PENDING                          registered scoreboard, one bit per register
//   LD_ERR                           sticky load protocol error
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALU_REQ,
  input  logic [ADDR_W-1:0] ALU_ADDR,
  input  logic [DATA_W-1:0] ALU_DATA,
  output logic              ALU_GNT,
  input  logic              LD_ISSUE,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic              LD_DONE,
  input  logic [DATA_W-1:0] LD_DATA,
  input  logic [ADDR_W-1:0] SRC1_ADDR,
  input  logic [ADDR_W-1:0] SRC2_ADDR,
  output logic              STALL,
  output logic              RF_WRITE,
  output logic [ADDR_W-1:0] RF_INADDRESS,
  output logic [DATA_W-1:0] RF_IN,
  output logic [NREG-1:0]   PENDING,
  output logic              LD_ERR
);

  localparam int CW = $clog2(QDEPTH) + 1;

  ld_state_e            state_q, state_d;
  logic [ADDR_W-1:0]    ld_dst_q, ld_dst_d;
  logic                 ld_err_q, ld_err_d;
  logic                 wb_valid_q, wb_valid_d;
  wr_req_t              wb_q, wb_d;
  logic [NREG-1:0]      pending_q, pending_d;

  logic                 ld_done_ok;
  logic                 alu_ok, alu_direct;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  wr_req_t [QDEPTH-1:0] fifo_entries;
  wr_req_t              alu_req;

  assign alu_req = '{addr: ALU_ADDR, data: ALU_DATA};

  rf_wq_fifo #(
    .DEPTH(QDEPTH)
  ) u_wq (
    .clk      (CLK),
    .rst_n    (RESET),
    .push     (fifo_push),
    .push_data(alu_req),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .entries  (fifo_entries)
  );

  // Load tracking. A DONE only counts while a load is outstanding; stray
  // DONEs and overlapping ISSUEs are flagged and otherwise ignored.
  always_comb begin
    state_d    = state_q;
    ld_dst_d   = ld_dst_q;
    ld_err_d   = ld_err_q;
    ld_done_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (LD_DONE) begin
          ld_err_d = 1'b1;
        end
        if (LD_ISSUE) begin
          state_d  = LOAD_WAIT;
          ld_dst_d = LD_ADDR;
        end
      end
      LOAD_WAIT: begin
        if (LD_DONE) begin
          ld_done_ok = 1'b1;
          if (LD_ISSUE) begin
            ld_dst_d = LD_ADDR;
          end else begin
            state_d = IDLE;
          end
        end else if (LD_ISSUE) begin
          ld_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write port arbitration: returning load data cannot wait, queued ALU
  // writes go next, and a fresh ALU write may bypass only an empty queue so
  // ALU writes commit in the order they were granted. An ALU write to the
  // outstanding load's destination is held off so it lands after the load.
  always_comb begin
    alu_ok     = ALU_REQ && !(state_q == LOAD_WAIT && ALU_ADDR == ld_dst_q);
    alu_direct = alu_ok && !ld_done_ok && fifo_empty;
    fifo_push  = alu_ok && !alu_direct && !fifo_full;
    fifo_pop   = !ld_done_ok && !fifo_empty;
    ALU_GNT    = alu_direct || fifo_push;
    wb_valid_d = ld_done_ok || fifo_pop || alu_direct;
    wb_d       = wb_q;
    if (ld_done_ok) begin
      wb_d = '{addr: ld_dst_q, data: LD_DATA};
    end else if (fifo_pop) begin
      wb_d = fifo_entries[0];
    end else if (alu_direct) begin
      wb_d = alu_req;
    end
  end

  // Scoreboard recomputed from where every uncommitted write will sit after
  // this edge, so a register stays pending while any copy remains in flight.
  always_comb begin
    pending_d = '0;
    if (state_d == LOAD_WAIT) begin
      pending_d[ld_dst_d] = 1'b1;
    end
    if (wb_valid_d) begin
      pending_d[wb_d.addr] = 1'b1;
    end
    for (int k = 0; k < QDEPTH; k++) begin
      if (k < int'(fifo_count) && !(fifo_pop && k == 0)) begin
        pending_d[fifo_entries[k].addr] = 1'b1;
      end
    end
    if (fifo_push) begin
      pending_d[ALU_ADDR] = 1'b1;
    end
  end

  // RAW hazard against every write not yet committed to the register file.
  always_comb begin
    STALL = 1'b0;
    if (state_q == LOAD_WAIT && (SRC1_ADDR == ld_dst_q || SRC2_ADDR == ld_dst_q)) begin
      STALL = 1'b1;
    end
    if (wb_valid_q && (SRC1_ADDR == wb_q.addr || SRC2_ADDR == wb_q.addr)) begin
      STALL = 1'b1;
    end
    for (int k = 0; k < QDEPTH; k++) begin
      if (k < int'(fifo_count) &&
          (SRC1_ADDR == fifo_entries[k].addr || SRC2_ADDR == fifo_entries[k].addr)) begin
        STALL = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      ld_dst_q   <= '0;
      ld_err_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
      pending_q  <= '0;
    end else begin
      state_q    <= state_d;
      ld_dst_q   <= ld_dst_d;
      ld_err_q   <= ld_err_d;
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
      pending_q  <= pending_d;
    end
  end

  assign RF_WRITE     = wb_valid_q;
  assign RF_INADDRESS = wb_q.addr;
  assign RF_IN        = wb_q.data;
  assign PENDING      = pending_q;
  assign LD_ERR       = ld_err_q;

endmodule
